// File: rtl/c17_magic_pkg.sv
// Shared types for the c17 MAGIC sequencer: FSM states, cell indices
// and the fixed six-step NAND schedule (dest = NAND(a, b)).
package c17_magic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int N_CELLS = 11;
    localparam int N_STEPS = 6;
    localparam logic [2:0] LAST_STEP = 3'd5;

    localparam logic [3:0] C_G1  = 4'd0;
    localparam logic [3:0] C_G2  = 4'd1;
    localparam logic [3:0] C_G3  = 4'd2;
    localparam logic [3:0] C_G6  = 4'd3;
    localparam logic [3:0] C_G7  = 4'd4;
    localparam logic [3:0] C_G10 = 4'd5;
    localparam logic [3:0] C_G11 = 4'd6;
    localparam logic [3:0] C_G16 = 4'd7;
    localparam logic [3:0] C_G19 = 4'd8;
    localparam logic [3:0] C_G22 = 4'd9;
    localparam logic [3:0] C_G23 = 4'd10;

    typedef struct packed {
        logic [3:0] dest;
        logic [3:0] a;
        logic [3:0] b;
    } sched_t;

    // Leftmost entry is step 5, rightmost is step 0.
    localparam sched_t [N_STEPS-1:0] SCHED = {
        sched_t'{dest: C_G23, a: C_G16, b: C_G19},
        sched_t'{dest: C_G22, a: C_G10, b: C_G16},
        sched_t'{dest: C_G19, a: C_G11, b: C_G7},
        sched_t'{dest: C_G16, a: C_G2,  b: C_G11},
        sched_t'{dest: C_G11, a: C_G3,  b: C_G6},
        sched_t'{dest: C_G10, a: C_G1,  b: C_G3}
    };

endpackage

// File: rtl/c17_magic_cells.sv
// 11-bit cell array: bulk load of inputs, one write port, two read ports.
// Ports: clk, rst_n, load/load_data, we/waddr/wdata, raddr_a/b, rdata_a/b, cells.
module c17_magic_cells
    import c17_magic_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [4:0]         load_data,
    input  logic               we,
    input  logic [3:0]         waddr,
    input  logic               wdata,
    input  logic [3:0]         raddr_a,
    input  logic [3:0]         raddr_b,
    output logic               rdata_a,
    output logic               rdata_b,
    output logic [N_CELLS-1:0] cells
);

    logic [N_CELLS-1:0] cells_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cells_q <= '0;
        end else if (load) begin
            // Inputs in cells 0..4, every gate output starts cleared.
            cells_q <= {{(N_CELLS-5){1'b0}}, load_data};
        end else if (we) begin
            cells_q[waddr] <= wdata;
        end
    end

    assign rdata_a = cells_q[raddr_a];
    assign rdata_b = cells_q[raddr_b];
    assign cells   = cells_q;

endmodule

// File: rtl/c17_magic_sequencer.sv
// Evaluates ISCAS c17 as a MAGIC-style NAND schedule, one cell write per cycle.
// Ports: clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/out_data, busy, step.
module c17_magic_sequencer
    import c17_magic_pkg::*;
#(
    parameter int INIT_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_data,
    output logic       busy,
    output logic [2:0] step
);

    localparam bit USE_INIT = (INIT_EN != 0);

    state_t             state;
    logic [2:0]         step_q;
    sched_t             ent;
    logic [N_CELLS-1:0] cells;
    logic               rd_a;
    logic               rd_b;
    logic               nand_ab;
    logic               accept;
    logic               in_init;
    logic               in_eval;
    logic               wr_bit;

    assign in_init = (state == ST_INIT);
    assign in_eval = (state == ST_EVAL);
    assign accept  = (state == ST_IDLE) && in_valid;
    assign ent     = SCHED[step_q];
    assign nand_ab = ~(rd_a & rd_b);

    // With initialise enabled the output cell was preset to 1, so the
    // evaluation can only pull it low, as a MAGIC NOR/NAND cell would.
    always_comb begin
        wr_bit = nand_ab;
        if (in_init) begin
            wr_bit = 1'b1;
        end else if (USE_INIT) begin
            wr_bit = cells[ent.dest] & nand_ab;
        end
    end

    c17_magic_cells u_cells (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (in_data),
        .we        (in_init | in_eval),
        .waddr     (ent.dest),
        .wdata     (wr_bit),
        .raddr_a   (ent.a),
        .raddr_b   (ent.b),
        .rdata_a   (rd_a),
        .rdata_b   (rd_b),
        .cells     (cells)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            step_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        step_q <= '0;
                        state  <= USE_INIT ? ST_INIT : ST_EVAL;
                    end
                end
                ST_INIT: begin
                    state <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (step_q == LAST_STEP) begin
                        state <= ST_DONE;
                    end else begin
                        step_q <= step_q + 3'd1;
                        state  <= USE_INIT ? ST_INIT : ST_EVAL;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = in_init | in_eval;
    assign step      = busy ? step_q : 3'd0;
    assign out_valid = (state == ST_DONE);
    assign out_data  = out_valid ? {cells[C_G23], cells[C_G22]} : 2'b00;

endmodule

// File: tb/tb_c17_magic_sequencer.sv
// Randomized scoreboard bench for c17_magic_sequencer, with and without
// the initialise cycle, against the c17 gate equations.
module tb_c17_magic_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [4:0] in_data   [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [1:0] out_data  [2];
    logic       busy      [2];
    logic [2:0] step      [2];

    int total = 0;
    int bad   = 0;

    logic [1:0] expq0[$];
    logic [1:0] expq1[$];
    bit         seen [2];
    logic [1:0] cur  [2];

    c17_magic_sequencer #(.INIT_EN(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0]), .step(step[0])
    );

    c17_magic_sequencer #(.INIT_EN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1]), .step(step[1])
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] c17_ref(input logic [4:0] d);
        logic g1, g2, g3, g6, g7;
        logic g10, g11, g16, g19, g22, g23;
        g1  = d[0];
        g2  = d[1];
        g3  = d[2];
        g6  = d[3];
        g7  = d[4];
        g10 = ~(g1 & g3);
        g11 = ~(g3 & g6);
        g16 = ~(g2 & g11);
        g19 = ~(g11 & g7);
        g22 = ~(g10 & g16);
        g23 = ~(g16 & g19);
        return {g23, g22};
    endfunction

    task automatic chk_eq(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected result per presented output and
    // checks that the result stays put until it is consumed.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (out_valid[u] === 1'b1) begin
                if (!seen[u]) begin
                    seen[u] = 1'b1;
                    if (u == 0 && expq0.size() > 0) begin
                        cur[u] = expq0.pop_front();
                        chk_eq("out_data0", out_data[u], cur[u]);
                    end else if (u == 1 && expq1.size() > 0) begin
                        cur[u] = expq1.pop_front();
                        chk_eq("out_data1", out_data[u], cur[u]);
                    end else begin
                        chk_eq("unexpected_out", 1, 0);
                    end
                end else begin
                    chk_eq("out_stable", out_data[u], cur[u]);
                end
            end else begin
                seen[u] = 1'b0;
            end
        end
    end

    task automatic run_vec(input int u, input logic [4:0] d, input int hold);
        int lat;
        int j;
        lat = (u == 1) ? 12 : 6;
        @(negedge clk);
        chk_eq("in_ready_idle", in_ready[u], 1);
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        @(posedge clk);
        if (u == 0) expq0.push_back(c17_ref(d));
        else        expq1.push_back(c17_ref(d));
        #1;
        chk_eq("busy_after_accept", busy[u], 1);
        for (j = 1; j <= lat + 3; j++) begin
            @(negedge clk);
            in_valid[u]  = 1'($urandom_range(0, 1));
            in_data[u]   = 5'($urandom);
            out_ready[u] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (out_valid[u]) break;
            chk_eq("step_seq", step[u], (u == 1) ? j / 2 : j);
        end
        chk_eq("latency", j, lat);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            out_ready[u] = 1'b0;
            in_valid[u]  = 1'b1;
            in_data[u]   = 5'($urandom);
            @(posedge clk);
            #1;
            chk_eq("hold_valid", out_valid[u], 1);
            chk_eq("hold_in_ready", in_ready[u], 0);
            chk_eq("done_busy", busy[u], 0);
            chk_eq("done_step", step[u], 0);
        end
        @(negedge clk);
        in_valid[u]  = 1'b0;
        out_ready[u] = 1'b1;
        chk_eq("hs_in_ready", in_ready[u], 0);
        @(posedge clk);
        #1;
        chk_eq("after_hs_valid", out_valid[u], 0);
        chk_eq("after_hs_ready", in_ready[u], 1);
        @(negedge clk);
        out_ready[u] = 1'b0;
    endtask

    task automatic reset_state(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk_eq({tag, "_in_ready"}, in_ready[u], 1);
            chk_eq({tag, "_out_valid"}, out_valid[u], 0);
            chk_eq({tag, "_out_data"}, out_data[u], 0);
            chk_eq({tag, "_busy"}, busy[u], 0);
            chk_eq({tag, "_step"}, step[u], 0);
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_data[1]  = 5'b10101;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk_eq("mid_step3", step[1], 3);
        chk_eq("mid_busy", busy[1], 1);
        rst_n = 1'b0;
        #1;
        reset_state("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            chk_eq("abandoned_valid", out_valid[1], 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            in_data[u]   = 5'd0;
            out_ready[u] = 1'b0;
        end
        #2;
        reset_state("por");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(1, 5'b00000, 1);
        run_vec(1, 5'b11111, 2);
        run_vec(1, 5'b00110, 5);
        run_vec(0, 5'b00110, 5);
        reset_mid();
        run_vec(1, 5'b00110, 0);

        for (int d = 0; d < 32; d++) begin
            run_vec(1, 5'(d), $urandom_range(0, 3));
            run_vec(0, 5'(d), $urandom_range(0, 3));
        end
        for (int i = 0; i < 20; i++) begin
            run_vec($urandom_range(0, 1), 5'($urandom), $urandom_range(0, 5));
        end

        repeat (3) @(negedge clk);
        chk_eq("q0_drained", expq0.size(), 0);
        chk_eq("q1_drained", expq1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c17_magic_sequencer.md
C17_MAGIC_SEQUENCER -- requirements
Module: c17_magic_sequencer

Interface
REQ-001 SHALL have parameter INIT_EN, default 1: 1 = inserts a MAGIC output-cell initialise cycle before each NAND evaluation; 0 = evaluate-only.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  input vector offered.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept a vector.
REQ-006 SHALL have port in_data  input  5  {G7,G6,G3,G2,G1}.
REQ-007 SHALL have port out_valid  output  1  result available.
REQ-008 SHALL have port out_ready  input  1  consumer accepts result.
REQ-009 SHALL have port out_data  output  2  {G23,G22}.
REQ-010 SHALL have port busy  output  1  high in INIT or EVAL.
REQ-011 SHALL have port step  output  3  current schedule index 0..5; 0 outside INIT/EVAL.

Function
REQ-012 SHALL keep an 11-bit cell array: cells 0..4 = G1,G2,G3,G6,G7; 5..10 = G10,G11,G16,G19,G22,G23.
REQ-013 SHALL execute a fixed 6-entry schedule (dest = NAND(a,b)): 0: 5=(0,2); 1: 6=(2,3); 2: 7=(1,6); 3: 8=(6,4); 4: 9=(5,7); 5: 10=(7,8).
REQ-014 SHALL implement FSM states IDLE, INIT, EVAL, DONE.
REQ-015 SHALL assert in_ready only in IDLE; accept on in_valid&&in_ready at edge k: load cells[4:0]=in_data, clear cells[10:5], step=0, move to INIT (INIT_EN=1) or EVAL (INIT_EN=0).
REQ-016 INIT SHALL set cell[dest(step)]=1, then move to EVAL.
REQ-017 EVAL SHALL write cell[dest] = cell[dest] & ~(cell[a]&cell[b]) when INIT_EN=1, ~(cell[a]&cell[b]) when INIT_EN=0; if step<5 increment step and go to INIT/EVAL; step=5 goes to DONE.
REQ-018 Latency: out_valid SHALL rise at edge k+12 (INIT_EN=1) or k+6 (INIT_EN=0); exactly one cell write per cycle.
REQ-019 In DONE, out_valid=1, out_data={cell[10],cell[9]}, stable until out_ready; out_valid&&out_ready returns to IDLE at that edge.
REQ-020 in_valid during busy or DONE SHALL be ignored (no load, no stall of the schedule); in_data need not be held.
REQ-021 out_ready asserted outside DONE SHALL have no effect.
REQ-022 No back-to-back overlap: in_ready SHALL be 0 in the cycle the DONE handshake occurs; new acceptance earliest one edge later.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, cells=0, step=0, in_ready=1 (while rst_n high thereafter), out_valid=0, out_data=0, busy=0.
REQ-024 Reset mid-schedule SHALL abandon the computation with no result ever presented.

Structure
REQ-025 Shared package c17_magic_pkg SHALL hold the state enum, cell-index constants, and the 6-entry schedule table (dest/a/b, 4 bits each).
REQ-026 One sub-module, c17_magic_cells (11-bit array, single write port, two combinational read ports), is permitted; FSM stays in the top.

Verification
REQ-027 in_data=5'b00000, INIT_EN=1 -> out_valid at edge k+12, out_data=2'b00.
REQ-028 in_data=5'b11111 -> out_data=2'b01; in_data=5'b00110 -> out_data=2'b11.
REQ-029 INIT_EN=0, in_data=5'b00110 -> out_valid at edge k+6, out_data=2'b11.
REQ-030 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable; in_valid pulsed meanwhile -> not accepted; all 32 input vectors vs c17 golden equations.
REQ-031 rst_n low at step 3 of EVAL -> same-cycle IDLE, out_valid never rises; next vector computes correctly.
